muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq_pkg.sv | 30 +++
 rtl/muldiv_seq_div_iter.sv | 60 ++++++
 rtl/muldiv_seq.sv | 151 +++++++++++++++
 tb/tb_muldiv_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared encodings and helpers for the EX-stage mul/div sequencer
//
// Contents:
//   MD_OP_*    : op encodings driven on muldiv_seq.op
//   md_state_e : sequencer states MD_IDLE / MD_MUL / MD_DIV / MD_DONE
//   DIV_ITER   : restoring-divider steps per divide
//   md_mag     : magnitude of an operand (two's complement negate when signed and negative)

package muldiv_seq_pkg;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    localparam int DIV_ITER = 32;

    // -2^31 maps onto 32'h80000000, which is still the correct unsigned magnitude.
    function automatic logic [31:0] md_mag(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_seq_div_iter.sv
// rtl/muldiv_seq_div_iter.sv - radix-2 restoring divider datapath, one step per enabled cycle
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   load        : capture dividend/divisor, clear partial remainder
//   step        : perform one restoring step
//   dividend    : unsigned dividend magnitude
//   divisor     : unsigned divisor magnitude
//   quotient    : quotient after the current step (combinational look-ahead)
//   remainder   : remainder after the current step (combinational look-ahead)
//
// The outputs show the result of the step being taken this cycle, so the owner
// can capture the final answer in the same cycle as the last step.

module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q, quo_q, dsr_q;
    logic [31:0] rem_d, quo_d;
    logic [32:0] rem_shift;
    logic [31:0] rem_sub;
    logic        fits;

    // Partial remainder is always below the divisor, so 32 bits hold it; the
    // shifted value needs one extra bit only for the trial compare.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        fits      = (rem_shift >= {1'b0, dsr_q});
        rem_sub   = rem_shift[31:0] - dsr_q;
        rem_d     = fits ? rem_sub : rem_shift[31:0];
        quo_d     = {quo_q[30:0], fits};
    end

    assign quotient  = quo_d;
    assign remainder = rem_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - EX-stage multi-cycle MULT/MULTU/DIV/DIVU sequencer
//
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   op_valid, op  : mul/div op present in EX and its encoding (MD_OP_*)
//   src_a, src_b  : rs / rt operands
//   flush         : abort any operation, return to idle
//   ex_stall_in   : EX held elsewhere; keeps a finished result presented
//   stall_o       : stall request to the hazard unit
//   result_valid  : HI/LO valid for the consumer
//   hi, lo        : HI/LO result
//
// Build option: MULDIV_EARLY_OUT_EN - finish a divide in one cycle when the
// divisor magnitude exceeds the dividend magnitude.

module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        ex_stall_in,
    output logic        stall_o,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_ITER - 1);

    md_state_e   state_q;
    logic [4:0]  cnt_q;
    logic [31:0] a_mag_q, b_mag_q;
    logic        neg_res_q;   // product / quotient negated
    logic        sign_a_q;    // remainder takes dividend sign
    logic [31:0] hi_q, lo_q;
    logic        result_valid_q;

    logic        is_signed, start;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod_mag, prod_fix;
    logic [31:0] quotient, remainder;

    assign is_signed = ~op[0];
    assign a_mag     = md_mag(src_a, is_signed);
    assign b_mag     = md_mag(src_b, is_signed);
    assign start     = (state_q == MD_IDLE) && op_valid && !flush;

    assign stall_o = start || (state_q == MD_MUL) || (state_q == MD_DIV);

    assign prod_mag = {32'd0, a_mag_q} * {32'd0, b_mag_q};
    assign prod_fix = neg_res_q ? (~prod_mag + 64'd1) : prod_mag;

    // Divider is loaded straight from the live operands in the accepting cycle.
    div_iter u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .load      (start && op[1]),
        .step      (state_q == MD_DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= MD_IDLE;
            cnt_q          <= '0;
            a_mag_q        <= '0;
            b_mag_q        <= '0;
            neg_res_q      <= 1'b0;
            sign_a_q       <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
            result_valid_q <= 1'b0;
        end else if (flush) begin
            state_q        <= MD_IDLE;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (op_valid) begin
                        a_mag_q   <= a_mag;
                        b_mag_q   <= b_mag;
                        neg_res_q <= is_signed && (src_a[31] ^ src_b[31]);
                        sign_a_q  <= is_signed && src_a[31];
                        if (!op[1]) begin
                            state_q <= MD_MUL;
                            cnt_q   <= MUL_CNT_INIT;
                        end else if (src_b == 32'd0) begin
                            hi_q           <= src_a;
                            lo_q           <= 32'hFFFF_FFFF;
                            state_q        <= MD_DONE;
                            result_valid_q <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                        end else if (b_mag > a_mag) begin
                            hi_q           <= src_a;
                            lo_q           <= 32'd0;
                            state_q        <= MD_DONE;
                            result_valid_q <= 1'b1;
`endif
                        end else begin
                            state_q <= MD_DIV;
                            cnt_q   <= DIV_CNT_INIT;
                        end
                    end
                end
                MD_MUL: begin
                    if (cnt_q == 5'd0) begin
                        {hi_q, lo_q}   <= prod_fix;
                        state_q        <= MD_DONE;
                        result_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                MD_DIV: begin
                    if (cnt_q == 5'd0) begin
                        lo_q           <= neg_res_q ? (~quotient + 32'd1) : quotient;
                        hi_q           <= sign_a_q ? (~remainder + 32'd1) : remainder;
                        state_q        <= MD_DONE;
                        result_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                MD_DONE: begin
                    if (!ex_stall_in) begin
                        state_q        <= MD_IDLE;
                        result_valid_q <= 1'b0;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign result_valid = result_valid_q;
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq

module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        ex_stall_in;
    logic        stall_o;
    logic        result_valid;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;
    int stalls;
    int rv_seen;

    always #5 clk = ~clk;

    muldiv_seq #(.MUL_LAT(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .op_valid     (op_valid),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .ex_stall_in  (ex_stall_in),
        .stall_o      (stall_o),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present an op for one cycle, then scramble the inputs while counting
    // cycles with stall_o high. Returns at a negedge (+1) with stall_o low.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        n = 0;
        while (stall_o === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            op_valid = 1'b0; op = ~o; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
            #1;
        end
    endtask

    task automatic check_result(input string tag, input int n, input int exp_n,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({tag, " stalls"}, 32'(n), 32'(exp_n));
        check({tag, " valid"}, {31'd0, result_valid}, 32'd1);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    task automatic check_release(input string tag);
        @(negedge clk); #1;
        check({tag, " valid drop"}, {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        flush = 1'b0; ex_stall_in = 1'b0;
        @(negedge clk); #1;
        check("rst stall", {31'd0, stall_o}, 32'd0);
        check("rst valid", {31'd0, result_valid}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, stalls);
        check_result("multu", stalls, 3, 32'd1, 32'hFFFF_FFFE);
        check_release("multu");

        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, stalls);
        check_result("div 7/-2", stalls, 33, 32'd1, 32'hFFFF_FFFD);
        check_release("div 7/-2");

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, stalls);
        check_result("div -7/2", stalls, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check_release("div -7/2");

        run_op(2'b11, 32'd100, 32'd0, stalls);
        check_result("divu by 0", stalls, 1, 32'd100, 32'hFFFF_FFFF);
        check_release("divu by 0");

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, stalls);
        check_result("div min/-1", stalls, 33, 32'd0, 32'h8000_0000);
        check_release("div min/-1");

`ifdef MULDIV_EARLY_OUT_EN
        run_op(2'b11, 32'd3, 32'd10, stalls);
        check_result("divu 3/10", stalls, 1, 32'd3, 32'd0);
`else
        run_op(2'b11, 32'd3, 32'd10, stalls);
        check_result("divu 3/10", stalls, 33, 32'd3, 32'd0);
`endif
        check_release("divu 3/10");

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, stalls);
        check_result("mult min*min", stalls, 3, 32'h4000_0000, 32'd0);
        check_release("mult min*min");

        // Result held while EX is stalled elsewhere.
        ex_stall_in = 1'b1;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, stalls);
        check_result("mult -3*5", stalls, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("hold valid", {31'd0, result_valid}, 32'd1);
            check("hold lo", lo, 32'hFFFF_FFF1);
        end
        ex_stall_in = 1'b0;
        @(negedge clk); #1;
        check("hold release valid", {31'd0, result_valid}, 32'd0);
        check("hold release stall", {31'd0, stall_o}, 32'd0);

        // Flush in the middle of a divide.
        @(negedge clk);
        op_valid = 1'b1; op = 2'b10; src_a = 32'd50; src_b = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        #1;
        check("flush pre stall", {31'd0, stall_o}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush stall", {31'd0, stall_o}, 32'd0);
        check("flush valid", {31'd0, result_valid}, 32'd0);
        check("flush hi kept", hi, 32'hFFFF_FFFF);
        check("flush lo kept", lo, 32'hFFFF_FFF1);
        rv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (result_valid !== 1'b0 || stall_o !== 1'b0) rv_seen++;
        end
        check("flush quiet", 32'(rv_seen), 32'd0);

        // Flush beats a simultaneous op_valid.
        @(negedge clk);
        op_valid = 1'b1; flush = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd3;
        #1;
        check("flush+op stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush+op idle", {31'd0, stall_o}, 32'd0);
        check("flush+op valid", {31'd0, result_valid}, 32'd0);

        // Reset mid-divide returns everything to reset values.
        @(negedge clk);
        op_valid = 1'b1; op = 2'b10; src_a = 32'd50; src_b = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("midrst stall", {31'd0, stall_o}, 32'd0);
        check("midrst valid", {31'd0, result_valid}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(2'b10, 32'd50, 32'd7, stalls);
        check_result("div 50/7", stalls, 33, 32'd1, 32'd7);
        check_release("div 50/7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
